// File: rtl/command_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : command_decoder
// Purpose  : Builds complete host commands from the UART byte stream.
//            Opcodes 0x00-0x7F are single-byte commands. Opcodes 0x80-0xFF
//            are followed by a 4-byte little-endian argument. If the gap
//            between bytes of a long command gets too large, the partial
//            command is discarded so the link can recover.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module command_decoder #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TCNT_W         = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  opcode,
  output logic [31:0] command,
  output logic        cmd_recv_rx,
  output logic        busy,
  output logic        timeout_err
);

  // Last count value before an idle cycle becomes a timeout.
  localparam logic [TCNT_W-1:0] c_tcnt_last = TCNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t             state_q,   state_d;
  logic [7:0]         sh_op_q,   sh_op_d;    // opcode of the command in progress
  logic [31:0]        sh_arg_q,  sh_arg_d;   // argument bytes gathered so far
  logic [1:0]         idx_q,     idx_d;      // next argument byte position
  logic [TCNT_W-1:0]  tcnt_q,    tcnt_d;     // idle cycles since the last byte
  logic [7:0]         opcode_q,  opcode_d;
  logic [31:0]        command_q, command_d;
  logic               strobe_q,  strobe_d;
  logic               tout_q,    tout_d;

  // State and output registers; reset drops any partial command silently.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      sh_op_q   <= 8'h00;
      sh_arg_q  <= 32'h0;
      idx_q     <= 2'd0;
      tcnt_q    <= '0;
      opcode_q  <= 8'h00;
      command_q <= 32'h0;
      strobe_q  <= 1'b0;
      tout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_op_q   <= sh_op_d;
      sh_arg_q  <= sh_arg_d;
      idx_q     <= idx_d;
      tcnt_q    <= tcnt_d;
      opcode_q  <= opcode_d;
      command_q <= command_d;
      strobe_q  <= strobe_d;
      tout_q    <= tout_d;
    end
  end

  // Next-state logic: byte assembly, completion and timeout handling.
  // The visible opcode/command only change on a completed command, so the
  // consumer can keep sampling them while a new long command is arriving.
  always_comb begin
    state_d   = state_q;
    sh_op_d   = sh_op_q;
    sh_arg_d  = sh_arg_q;
    idx_d     = idx_q;
    tcnt_d    = tcnt_q;
    opcode_d  = opcode_q;
    command_d = command_q;
    strobe_d  = 1'b0;
    tout_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          if (!rx_data[7]) begin
            opcode_d  = rx_data;
            command_d = 32'h0;
            strobe_d  = 1'b1;
          end else begin
            sh_op_d  = rx_data;
            sh_arg_d = 32'h0;
            idx_d    = 2'd0;
            tcnt_d   = '0;
            state_d  = COLLECT;
          end
        end
      end

      COLLECT: begin
        // A byte arriving on the expiry cycle still counts, so it is
        // checked before the timeout.
        if (rx_valid) begin
          tcnt_d = '0;
          idx_d  = idx_q + 2'd1;
          case (idx_q)
            2'd0:    sh_arg_d[7:0]   = rx_data;
            2'd1:    sh_arg_d[15:8]  = rx_data;
            2'd2:    sh_arg_d[23:16] = rx_data;
            default: sh_arg_d[31:24] = rx_data;
          endcase
          if (idx_q == 2'd3) begin
            opcode_d  = sh_op_q;
            command_d = {rx_data, sh_arg_q[23:0]};
            strobe_d  = 1'b1;
            idx_d     = 2'd0;
            state_d   = IDLE;
          end
        end else if (tcnt_q == c_tcnt_last) begin
          tout_d  = 1'b1;
          idx_d   = 2'd0;
          tcnt_d  = '0;
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign opcode      = opcode_q;
  assign command     = command_q;
  assign cmd_recv_rx = strobe_q;
  assign busy        = (state_q == COLLECT);
  assign timeout_err = tout_q;

endmodule
`default_nettype wire

// File: tb/tb_command_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_command_decoder
// Purpose  : Directed self-checking bench for command_decoder with a short
//            timeout (16 cycles).
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_command_decoder;

  logic        clock;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  opcode;
  logic [31:0] command;
  logic        cmd_recv_rx;
  logic        busy;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;
  int seen  = 0;

  command_decoder #(.TIMEOUT_CYCLES(16)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .opcode      (opcode),
    .command     (command),
    .cmd_recv_rx (cmd_recv_rx),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  // 10 time-unit clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance past one rising edge; outputs are then stable for sampling.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    idle(2);
    reset_n = 1'b1;

    // 1: reset state and a short command
    chk("rst_opcode",  32'(opcode), 32'h0);
    chk("rst_command", command,     32'h0);
    chk("rst_strobe",  32'(cmd_recv_rx), 32'h0);
    chk("rst_busy",    32'(busy),   32'h0);
    chk("rst_tout",    32'(timeout_err), 32'h0);
    send(8'h02);
    chk("t1_strobe",  32'(cmd_recv_rx), 32'h1);
    chk("t1_opcode",  32'(opcode), 32'h02);
    chk("t1_command", command, 32'h0);
    chk("t1_busy",    32'(busy), 32'h0);
    tick();
    chk("t1_strobe_off", 32'(cmd_recv_rx), 32'h0);

    // 2: long command with bytes 10 cycles apart
    send(8'h80);
    chk("t2_busy_on",   32'(busy), 32'h1);
    chk("t2_no_strobe", 32'(cmd_recv_rx), 32'h0);
    chk("t2_op_held0",  32'(opcode), 32'h02);
    idle(9); send(8'h78);
    idle(9); send(8'h56);
    idle(9); send(8'h34);
    idle(9);
    chk("t2_op_held",  32'(opcode), 32'h02);
    chk("t2_cmd_held", command, 32'h0);
    chk("t2_busy_mid", 32'(busy), 32'h1);
    send(8'h12);
    chk("t2_strobe",  32'(cmd_recv_rx), 32'h1);
    chk("t2_opcode",  32'(opcode), 32'h80);
    chk("t2_command", command, 32'h12345678);
    chk("t2_busy_off", 32'(busy), 32'h0);
    tick();
    chk("t2_strobe_off", 32'(cmd_recv_rx), 32'h0);

    // 3: timeout after a partial command
    send(8'hC0);
    send(8'hAA);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      seen += int'(timeout_err);
    end
    chk("t3_no_early_tout", 32'(seen), 32'h0);
    chk("t3_busy_before",   32'(busy), 32'h1);
    tick();
    chk("t3_tout",      32'(timeout_err), 32'h1);
    chk("t3_busy_off",  32'(busy), 32'h0);
    chk("t3_no_strobe", 32'(cmd_recv_rx), 32'h0);
    chk("t3_op_kept",   32'(opcode), 32'h80);
    chk("t3_cmd_kept",  command, 32'h12345678);
    tick();
    chk("t3_tout_once", 32'(timeout_err), 32'h0);
    send(8'h04);
    chk("t3_strobe",  32'(cmd_recv_rx), 32'h1);
    chk("t3_opcode",  32'(opcode), 32'h04);
    chk("t3_command", command, 32'h0);

    // 4: each byte arrives exactly on the expiry cycle
    send(8'h81);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 15; j++) begin
        tick();
        seen += int'(timeout_err);
      end
      send(8'h44 - 8'(i * 8'h11));
      seen += int'(timeout_err);
    end
    chk("t4_no_tout", 32'(seen), 32'h0);
    chk("t4_strobe",  32'(cmd_recv_rx), 32'h1);
    chk("t4_opcode",  32'(opcode), 32'h81);
    chk("t4_command", command, 32'h11223344);

    // 5: reset in the middle of a long command
    send(8'h82);
    send(8'h11);
    send(8'h22);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("t5_opcode",  32'(opcode), 32'h0);
    chk("t5_command", command, 32'h0);
    chk("t5_busy",    32'(busy), 32'h0);
    chk("t5_strobe",  32'(cmd_recv_rx), 32'h0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen += int'(timeout_err);
    end
    chk("t5_no_tout", 32'(seen), 32'h0);
    send(8'h00);
    chk("t5_strobe2", 32'(cmd_recv_rx), 32'h1);
    chk("t5_opcode2", 32'(opcode), 32'h00);

    // 6: back-to-back byte stream
    send(8'h01);
    chk("t6_s1",     32'(cmd_recv_rx), 32'h1);
    chk("t6_op1",    32'(opcode), 32'h01);
    chk("t6_cmd1",   command, 32'h0);
    send(8'h83);
    chk("t6_busy",   32'(busy), 32'h1);
    chk("t6_s_off",  32'(cmd_recv_rx), 32'h0);
    send(8'hFF);
    send(8'hFE);
    send(8'hFD);
    chk("t6_op_held", 32'(opcode), 32'h01);
    send(8'hFC);
    chk("t6_s2",     32'(cmd_recv_rx), 32'h1);
    chk("t6_op2",    32'(opcode), 32'h83);
    chk("t6_cmd2",   command, 32'hFCFDFEFF);
    send(8'h02);
    chk("t6_s3",     32'(cmd_recv_rx), 32'h1);
    chk("t6_op3",    32'(opcode), 32'h02);
    chk("t6_cmd3",   command, 32'h0);
    tick();
    chk("t6_s_end",  32'(cmd_recv_rx), 32'h0);
    chk("t6_tout",   32'(timeout_err), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
